cga_palette_dac: RTL



---
 rtl/cga_palette_dac.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cga_palette_dac.sv
// rtl/cga_palette_dac.sv - IRGB to 6:6:6 RGB palette DAC with VGA-DAC-style host port
module cga_palette_dac (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  video,
    input  logic        blank,
    output logic [17:0] rgb,
    input  logic        wr_idx_stb,
    input  logic        rd_idx_stb,
    input  logic        data_wr_stb,
    input  logic        data_rd_stb,
    input  logic [5:0]  din,
    output logic [5:0]  dout
);

    localparam logic [1:0] PH_R = 2'd0;
    localparam logic [1:0] PH_G = 2'd1;
    localparam logic [1:0] PH_B = 2'd2;

    // Standard CGA colour for an irgb index; entry 6 is brown rather than dark yellow.
    function automatic logic [17:0] default_color(input logic [3:0] idx);
        logic [5:0] lo;
        logic [5:0] hi;
        logic [5:0] g;
        lo = idx[3] ? 6'd21 : 6'd0;
        hi = idx[3] ? 6'd63 : 6'd42;
        g  = idx[1] ? hi : lo;
        if (idx == 4'd6) begin
            g = 6'd21;
        end
        return {(idx[2] ? hi : lo), g, (idx[0] ? hi : lo)};
    endfunction

    logic [17:0] r_palette [16];
    logic [3:0]  r_widx;
    logic [1:0]  r_wph;
    logic [5:0]  r_tr;
    logic [5:0]  r_tg;
    logic [3:0]  r_ridx;
    logic [1:0]  r_rph;
    logic [5:0]  r_dout;
    logic [3:0]  r_video_d;
    logic        r_blank_d;
    logic [17:0] r_rgb;

    logic        w_wr_data;
    logic        w_rd_data;
    logic        w_commit;
    logic [17:0] w_rd_entry;

    // An index strobe takes precedence over a data strobe of the same direction.
    assign w_wr_data  = data_wr_stb && !wr_idx_stb;
    assign w_rd_data  = data_rd_stb && !rd_idx_stb;
    assign w_commit   = w_wr_data && (r_wph == PH_B);
    assign w_rd_entry = r_palette[r_ridx];

    // Palette storage: defaults on reset, whole-entry update only at the B commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_palette[i] <= default_color(4'(i));
            end
        end else if (w_commit) begin
            r_palette[r_widx] <= {r_tr, r_tg, din};
        end
    end

    // Write sequencer: collect R and G in holding registers, advance index after B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_widx <= 4'd0;
            r_wph  <= PH_R;
            r_tr   <= 6'd0;
            r_tg   <= 6'd0;
        end else if (wr_idx_stb) begin
            r_widx <= din[3:0];
            r_wph  <= PH_R;
        end else if (w_wr_data) begin
            case (r_wph)
                PH_R: begin
                    r_tr  <= din;
                    r_wph <= PH_G;
                end
                PH_G: begin
                    r_tg  <= din;
                    r_wph <= PH_B;
                end
                default: begin
                    r_widx <= r_widx + 4'd1;
                    r_wph  <= PH_R;
                end
            endcase
        end
    end

    // Read sequencer: return one component per strobe, advance index after B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ridx <= 4'd0;
            r_rph  <= PH_R;
            r_dout <= 6'd0;
        end else if (rd_idx_stb) begin
            r_ridx <= din[3:0];
            r_rph  <= PH_R;
        end else if (w_rd_data) begin
            case (r_rph)
                PH_G: begin
                    r_dout <= w_rd_entry[11:6];
                    r_rph  <= PH_B;
                end
                PH_B: begin
                    r_dout <= w_rd_entry[5:0];
                    r_rph  <= PH_R;
                    r_ridx <= r_ridx + 4'd1;
                end
                default: begin
                    r_dout <= w_rd_entry[17:12];
                    r_rph  <= PH_G;
                end
            endcase
        end
    end

    // Pixel path: register the pixel and blank, then look up and register the colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_video_d <= 4'd0;
            r_blank_d <= 1'b1;
            r_rgb     <= 18'd0;
        end else begin
            r_video_d <= video;
            r_blank_d <= blank;
            r_rgb     <= r_blank_d ? 18'd0 : r_palette[r_video_d];
        end
    end

    assign rgb  = r_rgb;
    assign dout = r_dout;

endmodule
